// File: rtl/vga_write_arbiter_if.sv
// Requester-side bus of the VGA write arbiter: three drawing engines share one
// pixel-write port.
// Signals (requester i occupies bit i / slice [i*W +: W]):
//   req, pix_valid, pix_last      : per-requester burst request, pixel valid, last pixel
//   pix_x, pix_y, pix_color       : packed per-requester pixel fields
//   pix_ready                     : pixel accepted this cycle (combinational)
//   grant, busy                   : one-hot current owner, arbiter in a burst (registered)
// Modports: master = drawing engines, slave = arbiter.
interface vga_write_arbiter_if #(
  parameter int unsigned nX          = 10,
  parameter int unsigned nY          = 9,
  parameter int unsigned COLOR_DEPTH = 9
);
  logic [2:0]               req;
  logic [2:0]               pix_valid;
  logic [2:0]               pix_last;
  logic [3*nX-1:0]          pix_x;
  logic [3*nY-1:0]          pix_y;
  logic [3*COLOR_DEPTH-1:0] pix_color;
  logic [2:0]               pix_ready;
  logic [2:0]               grant;
  logic                     busy;

  modport master (
    output req, pix_valid, pix_last, pix_x, pix_y, pix_color,
    input  pix_ready, grant, busy
  );

  modport slave (
    input  req, pix_valid, pix_last, pix_x, pix_y, pix_color,
    output pix_ready, grant, busy
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the single vga_adapter pixel-write port between
// the player sprite (0), obstacle renderer (1) and HUD renderer (2). A grant
// covers a whole sprite burst; the owner's accepted pixels are forwarded one
// cycle later on the registered VGA_* outputs. One IDLE cycle separates bursts.
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   bus (slave)       : requester bus, see vga_write_arbiter_if
//   VGA_x, VGA_y      : registered pixel coordinates to the adapter
//   VGA_color         : registered pixel color
//   VGA_write         : registered write strobe
// Optional feature: define VGA_ARB_BURST_LIMIT_EN to end a grant after
// MAX_BURST accepted pixels so one engine cannot hog the port.
module vga_write_arbiter #(
  parameter int unsigned nX          = 10,
  parameter int unsigned nY          = 9,
  parameter int unsigned COLOR_DEPTH = 9,
  parameter int unsigned MAX_BURST   = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_write_arbiter_if.slave     bus,
  output logic [nX-1:0]          VGA_x,
  output logic [nY-1:0]          VGA_y,
  output logic [COLOR_DEPTH-1:0] VGA_color,
  output logic                   VGA_write
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state;
  logic [1:0]             last_winner;   // also the current owner while in GRANT
  logic                   accept;
  logic                   accept_last;
  logic                   owner_req;
  logic                   limit_hit;
  logic [1:0]             win_idx;
  logic [2:0]             win_oh;
  logic [nX-1:0]          sel_x;
  logic [nY-1:0]          sel_y;
  logic [COLOR_DEPTH-1:0] sel_color;

  // Only the owner can be accepted; grant is zero in IDLE so this also gates IDLE.
  always_comb begin
    bus.pix_ready = 3'b000;
    if (state == GRANT) begin
      bus.pix_ready = bus.pix_valid & bus.grant;
    end
  end

  // Owner-qualified handshake terms.
  always_comb begin
    accept      = |bus.pix_ready;
    accept_last = |(bus.pix_ready & bus.pix_last);
    owner_req   = |(bus.req & bus.grant);
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    win_idx = 2'd0;
    found   = 1'b0;
    cand    = (last_winner == 2'd2) ? 2'd0 : last_winner + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && bus.req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
    win_oh = 3'b001 << win_idx;
  end

  // Owner's pixel fields.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    case (last_winner)
      2'd0: begin
        sel_x     = bus.pix_x[0*nX +: nX];
        sel_y     = bus.pix_y[0*nY +: nY];
        sel_color = bus.pix_color[0*COLOR_DEPTH +: COLOR_DEPTH];
      end
      2'd1: begin
        sel_x     = bus.pix_x[1*nX +: nX];
        sel_y     = bus.pix_y[1*nY +: nY];
        sel_color = bus.pix_color[1*COLOR_DEPTH +: COLOR_DEPTH];
      end
      2'd2: begin
        sel_x     = bus.pix_x[2*nX +: nX];
        sel_y     = bus.pix_y[2*nY +: nY];
        sel_color = bus.pix_color[2*COLOR_DEPTH +: COLOR_DEPTH];
      end
      default: begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
      end
    endcase
  end

`ifdef VGA_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt;

  // Fires on the MAX_BURST-th accepted pixel of the current grant.
  always_comb begin
    limit_hit = accept && (burst_cnt == CNT_W'(MAX_BURST - 1));
  end

  // Accepted-pixel count per grant; held at zero in IDLE so each grant starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end
`else
  // No counter in this build: a burst ends only on its last pixel or on abort.
  always_comb begin
    limit_hit = (MAX_BURST == 0) && 1'b0;
  end
`endif

  // Arbitration FSM and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 2'd2;
      bus.grant   <= 3'b000;
      bus.busy    <= 1'b0;
      VGA_x       <= '0;
      VGA_y       <= '0;
      VGA_color   <= '0;
      VGA_write   <= 1'b0;
    end else begin
      VGA_write <= accept;
      if (accept) begin
        VGA_x     <= sel_x;
        VGA_y     <= sel_y;
        VGA_color <= sel_color;
      end

      case (state)
        IDLE: begin
          if (|bus.req) begin
            state       <= GRANT;
            bus.grant   <= win_oh;
            last_winner <= win_idx;
            bus.busy    <= 1'b1;
          end
        end
        GRANT: begin
          // A pixel presented alongside an abort is still accepted above.
          if (accept_last || !owner_req || limit_hit) begin
            state     <= IDLE;
            bus.grant <= 3'b000;
            bus.busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus.grant <= 3'b000;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: a per-cycle vector table covering
// reset, round-robin order, stall, abort, a 4-pixel burst and reset mid-burst,
// followed by a long-stream sequence whose grant segmentation depends on
// whether VGA_ARB_BURST_LIMIT_EN is defined (MAX_BURST = 4 here).
module tb_vga_write_arbiter;

  localparam int unsigned NX = 10;
  localparam int unsigned NY = 9;
  localparam int unsigned NC = 9;

  logic          clk;
  logic          reset;
  logic [NX-1:0] vga_x;
  logic [NY-1:0] vga_y;
  logic [NC-1:0] vga_color;
  logic          vga_write;

  vga_write_arbiter_if #(.nX(NX), .nY(NY), .COLOR_DEPTH(NC)) bus ();

  vga_write_arbiter #(
    .nX(NX), .nY(NY), .COLOR_DEPTH(NC), .MAX_BURST(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .VGA_x     (vga_x),
    .VGA_y     (vga_y),
    .VGA_color (vga_color),
    .VGA_write (vga_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [2:0]    req;
    logic [2:0]    valid;
    logic [2:0]    last;
    int            src;
    logic [NX-1:0] x;
    logic [NY-1:0] y;
    logic [NC-1:0] c;
    logic [2:0]    e_ready;
    logic [2:0]    e_grant;
    logic          e_busy;
    logic          e_write;
    logic [NX-1:0] e_x;
    logic [NY-1:0] e_y;
    logic [NC-1:0] e_c;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic [2:0] valid,
                     input logic [2:0] last, input int src, input int x, input int y,
                     input int c, input logic [2:0] e_ready, input logic [2:0] e_grant,
                     input logic e_busy, input logic e_write, input int e_x,
                     input int e_y, input int e_c);
    vec_t v;
    v.rst = rst; v.req = req; v.valid = valid; v.last = last; v.src = src;
    v.x = NX'(x); v.y = NY'(y); v.c = NC'(c);
    v.e_ready = e_ready; v.e_grant = e_grant; v.e_busy = e_busy; v.e_write = e_write;
    v.e_x = NX'(e_x); v.e_y = NY'(e_y); v.e_c = NC'(e_c);
    vecs.push_back(v);
  endtask

  // Requester src gets the given fields; the others get the inverse so a wrong mux shows.
  task automatic drive(input logic rst, input logic [2:0] req, input logic [2:0] valid,
                       input logic [2:0] last, input int src, input logic [NX-1:0] x,
                       input logic [NY-1:0] y, input logic [NC-1:0] c);
    reset         = rst;
    bus.req       = req;
    bus.pix_valid = valid;
    bus.pix_last  = last;
    for (int i = 0; i < 3; i++) begin
      bus.pix_x[i*NX +: NX]     = (i == src) ? x : ~x;
      bus.pix_y[i*NY +: NY]     = (i == src) ? y : ~y;
      bus.pix_color[i*NC +: NC] = (i == src) ? c : ~c;
    end
  endtask

`ifdef VGA_ARB_BURST_LIMIT_EN
  localparam int NSEG = 5;
  int exp_own[NSEG] = '{2, 0, 2, 0, 2};
  int exp_len[NSEG] = '{4, 2, 4, 2, 2};
`else
  localparam int NSEG = 3;
  int exp_own[NSEG] = '{2, 0, 0};
  int exp_len[NSEG] = '{10, 2, 2};
`endif

  initial begin
    vec_t v;
    int   p0, p2, seg_cnt, cyc, g_idx;
    logic [2:0] g, valid, last, req;
    logic [NX-1:0] px;
    logic acc;
    int   seg_own[$];
    int   seg_len[$];

    // Reset held 2 cycles with all requests high.
    add(1, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b000, 0, 0, 0, 0, 0);
    add(1, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b000, 0, 0, 0, 0, 0);
    // Round-robin, 2-pixel bursts; non-owner valid/last ignored.
    add(0, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b001, 1, 0, 0, 0, 0);
    add(0, 3'b111, 3'b001, 3'b000, 0, 1, 2, 3,   3'b001, 3'b001, 1, 1, 1, 2, 3);
    add(0, 3'b111, 3'b001, 3'b001, 0, 4, 5, 6,   3'b001, 3'b000, 0, 1, 4, 5, 6);
    add(0, 3'b111, 3'b111, 3'b111, 0, 7, 7, 7,   3'b000, 3'b010, 1, 0, 4, 5, 6);
    add(0, 3'b111, 3'b010, 3'b000, 1, 10, 11, 12, 3'b010, 3'b010, 1, 1, 10, 11, 12);
    add(0, 3'b111, 3'b110, 3'b110, 1, 13, 14, 15, 3'b010, 3'b000, 0, 1, 13, 14, 15);
    add(0, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b100, 1, 0, 13, 14, 15);
    add(0, 3'b111, 3'b100, 3'b000, 2, 20, 21, 22, 3'b100, 3'b100, 1, 1, 20, 21, 22);
    add(0, 3'b111, 3'b100, 3'b100, 2, 23, 24, 25, 3'b100, 3'b000, 0, 1, 23, 24, 25);
    add(0, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b001, 1, 0, 23, 24, 25);
    // Requester 0 stalls 3 cycles, then aborts with a final pixel; requester 2 next.
    add(0, 3'b101, 3'b001, 3'b000, 0, 30, 31, 32, 3'b001, 3'b001, 1, 1, 30, 31, 32);
    for (int i = 0; i < 3; i++)
      add(0, 3'b101, 3'b100, 3'b100, 2, 99, 99, 99, 3'b000, 3'b001, 1, 0, 30, 31, 32);
    add(0, 3'b100, 3'b001, 3'b000, 0, 33, 34, 35, 3'b001, 3'b000, 0, 1, 33, 34, 35);
    add(0, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b100, 1, 0, 33, 34, 35);
    add(0, 3'b100, 3'b100, 3'b100, 2, 40, 41, 42, 3'b100, 3'b000, 0, 1, 40, 41, 42);
    // Single 4-pixel burst from requester 1.
    add(0, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b010, 1, 0, 40, 41, 42);
    for (int i = 0; i < 3; i++)
      add(0, 3'b010, 3'b010, 3'b000, 1, 100 + i, 50, 9'h1C0,
          3'b010, 3'b010, 1, 1, 100 + i, 50, 9'h1C0);
    add(0, 3'b010, 3'b010, 3'b010, 1, 103, 50, 9'h1C0, 3'b010, 3'b000, 0, 1, 103, 50, 9'h1C0);
    add(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b000, 0, 0, 103, 50, 9'h1C0);
    // Reset after 2 of 5 pixels; pointer returns to 2 so requester 0 wins again.
    add(0, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b001, 1, 0, 103, 50, 9'h1C0);
    add(0, 3'b001, 3'b001, 3'b000, 0, 60, 61, 62, 3'b001, 3'b001, 1, 1, 60, 61, 62);
    add(0, 3'b001, 3'b001, 3'b000, 0, 63, 64, 65, 3'b001, 3'b001, 1, 1, 63, 64, 65);
    add(1, 3'b001, 3'b001, 3'b000, 0, 66, 67, 68, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    add(0, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000, 3'b001, 1, 0, 0, 0, 0);
    add(0, 3'b000, 3'b001, 3'b000, 0, 70, 71, 72, 3'b001, 3'b000, 0, 1, 70, 71, 72);

    drive(1'b1, 3'b000, 3'b000, 3'b000, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.rst, v.req, v.valid, v.last, v.src, v.x, v.y, v.c);
      #1;
      chk($sformatf("row%0d pix_ready", i), 32'(bus.pix_ready), 32'(v.e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d grant", i), 32'(bus.grant), 32'(v.e_grant));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(v.e_busy));
      chk($sformatf("row%0d VGA_write", i), 32'(vga_write), 32'(v.e_write));
      chk($sformatf("row%0d VGA_x", i), 32'(vga_x), 32'(v.e_x));
      chk($sformatf("row%0d VGA_y", i), 32'(vga_y), 32'(v.e_y));
      chk($sformatf("row%0d VGA_color", i), 32'(vga_color), 32'(v.e_c));
    end

    // Requester 2 streams 10 pixels while requester 0 sends two 2-pixel bursts.
    p0 = 0; p2 = 0; seg_cnt = 0; cyc = 0;
    while (!(p0 == 4 && p2 == 10 && bus.grant == 3'b000) && cyc < 300) begin
      g     = bus.grant;
      req   = {p2 < 10, 1'b0, p0 < 4};
      valid = 3'b000;
      last  = 3'b000;
      px    = '0;
      g_idx = 0;
      if (g == 3'b100 && p2 < 10) begin
        valid = 3'b100; last = {p2 == 9, 2'b00}; px = NX'(p2); g_idx = 2;
      end else if (g == 3'b001 && p0 < 4) begin
        valid = 3'b001; last = {2'b00, p0[0]}; px = NX'(500 + p0); g_idx = 0;
      end
      acc = (valid != 3'b000);
      drive(1'b0, req, valid, last, g_idx, px, NY'(7), NC'(g_idx));
      @(posedge clk);
      #1;
      cyc++;
      chk("stream VGA_write", 32'(vga_write), 32'(acc));
      if (acc) begin
        chk("stream VGA_x", 32'(vga_x), 32'(px));
        seg_cnt++;
        if (g_idx == 2) p2++;
        else p0++;
      end
      if (g != 3'b000 && bus.grant == 3'b000) begin
        seg_own.push_back((g == 3'b100) ? 2 : (g == 3'b010) ? 1 : 0);
        seg_len.push_back(seg_cnt);
        seg_cnt = 0;
      end
    end
    chk("stream finished within budget", 32'(cyc < 300), 32'd1);
    chk("segment count", 32'(seg_own.size()), 32'(NSEG));
    for (int i = 0; i < NSEG; i++) begin
      if (i < seg_own.size()) begin
        chk($sformatf("segment%0d owner", i), 32'(seg_own[i]), 32'(exp_own[i]));
        chk($sformatf("segment%0d writes", i), 32'(seg_len[i]), 32'(exp_len[i]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
# vga_write_arbiter

Shares the single pixel-write port of the 640x480 VGA adapter between three drawing engines: player sprite, obstacle renderer and score/HUD renderer. Each engine raises a request for a whole sprite burst. The arbiter grants one engine at a time in round-robin order and forwards that engine's pixels as registered x/y/color/write outputs. It sits between the game-object drawers and the `vga_adapter` instance in the top level.

## Interface
Parameters:
- `nX`, 10, X coordinate width (640 columns)
- `nY`, 9, Y coordinate width (480 rows)
- `COLOR_DEPTH`, 9, pixel color width (RGB 3-3-3)
- `MAX_BURST`, 256, pixel limit per grant; used only when `VGA_ARB_BURST_LIMIT_EN` is defined

Ports:
- `clk` in 1: system clock (CLOCK_50). Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `req` in 3: per-requester burst request, held high for the whole sprite. Index 0 = player, 1 = obstacles, 2 = HUD.
- `pix_valid` in 3: per-requester pixel valid.
- `pix_last` in 3: marks the final pixel of the burst. Qualified by `pix_valid`.
- `pix_x` in 3*nX: packed X coordinates; requester i occupies `[i*nX +: nX]`.
- `pix_y` in 3*nY: packed Y coordinates.
- `pix_color` in 3*COLOR_DEPTH: packed colors.
- `pix_ready` out 3: pixel accepted this cycle. Combinational.
- `grant` out 3: one-hot current owner. Registered.
- `busy` out 1: high while in GRANT.
- `VGA_x` out nX, `VGA_y` out nY, `VGA_color` out COLOR_DEPTH, `VGA_write` out 1: to the vga_adapter write port. Registered.

## Operation
- FSM states:
  - IDLE: `grant`=0.
  - GRANT: exactly one `grant` bit set.
- IDLE -> GRANT when any `req` bit is high.
  - The winner is the first requester with `req` high, searching upward from `(last_winner+1) mod 3`.
  - `grant` and `last_winner` are updated on the same edge.
- In GRANT with owner g:
  - `pix_ready[g] = pix_valid[g]`. All other `pix_ready` bits are 0.
  - An accepted pixel is `pix_valid[g]` && `pix_ready[g]`.
- Accepted pixel: on the next edge, `VGA_x/VGA_y/VGA_color` load requester g's fields and `VGA_write`=1.
  - Otherwise `VGA_write`=0 and x/y/color hold their last values.
- GRANT -> IDLE on the edge at which any of these occurs:
  - an accepted pixel with `pix_last[g]`=1;
  - `req[g]` deasserts (abort; any pixel presented in that cycle is still accepted);
  - the burst limit is reached (configurable, see Configuration).
- There is always one IDLE cycle between bursts, so the maximum port utilisation is (burst)/(burst+1).
- Inputs from non-granted requesters, including `pix_valid`/`pix_last`, are ignored with no side effects.
- `pix_valid` is sampled only while granted. A requester may drop valid mid-burst (stall); the grant is kept.
- No coordinate clamping: coordinates pass through unmodified. Range checking belongs to the drawers.

## Timing
- Reset values:
  - `grant`=000, `busy`=0, `VGA_write`=0
  - `VGA_x`=0, `VGA_y`=0, `VGA_color`=0
  - state IDLE
  - `last_winner`=2, so requester 0 wins first.
- Arbitration latency: `req` high in cycle N (port idle) -> `grant` high in cycle N+1 -> first `pix_ready` possible in N+1 -> `VGA_write` in N+2.
- Pixel latency: exactly 1 cycle from acceptance to `VGA_write`.
- Reset mid-burst:
  - `VGA_write` is 0 the cycle after `reset` is sampled high.
  - The in-flight pixel is dropped.
  - The pointer returns to its reset value.
- Simultaneous `req` from all three: grants go 0, 1, 2, 0, ... with one IDLE cycle between each.
- A `req` that rises in the same cycle as a GRANT->IDLE transition is considered in the following IDLE cycle.

## Configuration
- Macro: `VGA_ARB_BURST_LIMIT_EN`.
- Defined:
  - A pixel counter of width `$clog2(MAX_BURST+1)` counts accepted pixels per grant.
  - On the MAX_BURST-th accepted pixel, the FSM returns to IDLE even without `pix_last`, and the pointer rotates.
  - The requester keeps `req` high and resumes its stream at its next grant; no pixel is lost or duplicated.
  - The counter clears on every entry to GRANT.
- Undefined: no counter is implemented and bursts are unbounded. A requester holding `req` with `pix_valid` low blocks the port indefinitely.

## Test plan
- Reset: hold `reset` for 2 cycles with all `req` high -> `grant`=000 and `VGA_write`=0 throughout. First `grant`=001 one cycle after release.
- Single burst: requester 1 sends 4 pixels (x=100..103, y=50, color=9'h1C0), last on the 4th -> `VGA_write` high for exactly 4 consecutive cycles with matching x/y/color, then `busy`=0.
- Round-robin: all `req` high, 2-pixel bursts each -> grant order 001, 010, 100, 001, with one idle cycle between grants.
- Stall/abort: requester 0 drops `pix_valid` for 3 cycles mid-burst -> grant held and no writes. Requester 0 then drops `req` -> IDLE next cycle and requester 2 granted.
- Reset mid-burst: assert `reset` after 2 of 5 pixels -> `VGA_write`=0 next cycle and `grant`=000.
- Burst limit (macro defined, MAX_BURST=4): requester 2 streams 10 pixels with requester 0 waiting -> write counts of 4 (req2), 0's burst, 4 (req2), 0's burst, 2 (req2).
